// File: rtl/btn_pkg.sv
// Shared types and constants for the push-button conditioning path:
// channel state encoding, button index map and 100 MHz default timings.
package btn_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        ARM         = 3'd1,
        HELD_DELAY  = 3'd2,
        HELD_REPEAT = 3'd3,
        RELEASE     = 3'd4
    } chan_state_e;

    localparam int NUM_BTN   = 4;
    localparam int BTN_UP    = 0;
    localparam int BTN_DOWN  = 1;
    localparam int BTN_LEFT  = 2;
    localparam int BTN_RIGHT = 3;

    localparam int DEF_DEB_CYCLES = 1000000;
    localparam int DEF_REP_DELAY  = 25000000;
    localparam int DEF_REP_PERIOD = 2000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return m;
    endfunction

    // Counter only ever needs to reach (largest interval - 1).
    function automatic int cnt_width(input int a, input int b, input int c);
        int w;
        w = $clog2(max3(a, b, c));
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce/auto-repeat FSM and
// its shared interval counter, producing a debounced level and a strobe.
module debounce_channel
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD,
    parameter int REP_EN     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = cnt_width(DEB_CYCLES, REP_DELAY, REP_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REP_PERIOD - 1);

    logic             sync1_r;
    logic             sync2_r;
    chan_state_e      state_r;
    chan_state_e      state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             level_r;
    logic             level_next_s;
    logic             pulse_r;
    logic             pulse_next_s;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= raw;
            sync2_r <= sync1_r;
        end
    end

    // State, counter and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= CNT_ZERO;
            level_r <= 1'b0;
            pulse_r <= 1'b0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            level_r <= level_next_s;
            pulse_r <= pulse_next_s;
        end
    end

    // Next-state logic; the counter is cleared on every transition.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        level_next_s = level_r;
        pulse_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (sync2_r) begin
                    state_next_s = ARM;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s   = CNT_ZERO;
                end
            end
            ARM: begin
                if (!sync2_r) begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_next_s = HELD_DELAY;
                    cnt_next_s   = CNT_ZERO;
                    level_next_s = 1'b1;
                    pulse_next_s = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            HELD_DELAY: begin
                if (!sync2_r) begin
                    state_next_s = RELEASE;
                    cnt_next_s   = CNT_ZERO;
                end else if ((REP_EN != 0) && (cnt_r == DELAY_LAST)) begin
                    state_next_s = HELD_REPEAT;
                    cnt_next_s   = CNT_ZERO;
                    pulse_next_s = 1'b1;
                end else if (cnt_r == DELAY_LAST) begin
                    // Repeat disabled: park the counter rather than wrap.
                    cnt_next_s   = cnt_r;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            HELD_REPEAT: begin
                if (!sync2_r) begin
                    state_next_s = RELEASE;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == PERIOD_LAST) begin
                    cnt_next_s   = CNT_ZERO;
                    pulse_next_s = 1'b1;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            RELEASE: begin
                if (sync2_r) begin
                    state_next_s = HELD_DELAY;
                    cnt_next_s   = CNT_ZERO;
                end else if (cnt_r == DEB_LAST) begin
                    state_next_s = IDLE;
                    cnt_next_s   = CNT_ZERO;
                    level_next_s = 1'b0;
                end else begin
                    cnt_next_s   = cnt_r + CNT_ONE;
                end
            end
            default: begin
                state_next_s = IDLE;
                cnt_next_s   = CNT_ZERO;
                level_next_s = 1'b0;
            end
        endcase
    end

    assign level = level_r;
    assign pulse = pulse_r;

endmodule

// File: rtl/button_conditioner.sv
// Four debounced, auto-repeating button channels plus a one-hot move
// arbiter (right > left > up > down) feeding the block-movement stage.
module button_conditioner
    import btn_pkg::*;
#(
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int REP_DELAY  = DEF_REP_DELAY,
    parameter int REP_PERIOD = DEF_REP_PERIOD,
    parameter int REP_EN     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] btn_raw,
    output logic [3:0] btn_level,
    output logic [3:0] btn_pulse,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right
);

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_chan
        debounce_channel #(
            .DEB_CYCLES (DEB_CYCLES),
            .REP_DELAY  (REP_DELAY),
            .REP_PERIOD (REP_PERIOD),
            .REP_EN     (REP_EN)
        ) u_chan (
            .clk   (clk),
            .rst   (rst),
            .raw   (btn_raw[i]),
            .level (btn_level[i]),
            .pulse (btn_pulse[i])
        );
    end

    // Losing strobes are dropped; btn_pulse still carries every channel.
    assign move_right = btn_pulse[BTN_RIGHT];
    assign move_left  = btn_pulse[BTN_LEFT] & ~btn_pulse[BTN_RIGHT];
    assign move_up    = btn_pulse[BTN_UP] & ~btn_pulse[BTN_RIGHT] & ~btn_pulse[BTN_LEFT];
    assign move_down  = btn_pulse[BTN_DOWN] & ~btn_pulse[BTN_RIGHT] & ~btn_pulse[BTN_LEFT]
                      & ~btn_pulse[BTN_UP];

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a run-length reference model predicts level/pulse/move
// per edge, a negedge monitor pops and compares against the DUT.
module tb_button_conditioner;

    localparam int DEB = 4;
    localparam int DLY = 10;
    localparam int PER = 3;
    localparam int REN = 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn_raw = 4'b0000;
    logic [3:0] btn_level;
    logic [3:0] btn_pulse;
    logic       move_up;
    logic       move_down;
    logic       move_left;
    logic       move_right;

    button_conditioner #(
        .DEB_CYCLES (DEB),
        .REP_DELAY  (DLY),
        .REP_PERIOD (PER),
        .REP_EN     (REN)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .btn_level  (btn_level),
        .btn_pulse  (btn_pulse),
        .move_up    (move_up),
        .move_down  (move_down),
        .move_left  (move_left),
        .move_right (move_right)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] level;
        logic [3:0] pulse;
        logic [3:0] move;   // {right, left, down, up}
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    // Reference state: raw history (synchronizer delay) and run lengths.
    int hist1[4];
    int hist2[4];
    int lvl[4];
    int ones_run[4];
    int zeros_run[4];
    int hold_t[4];

    bit rec_on   = 1'b0;
    int rec_base = 0;
    int rec_log[$];

    task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s edge=%0d got=%b want=%b", name, cyc, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            hist1[i] = 0; hist2[i] = 0; lvl[i] = 0;
            ones_run[i] = 0; zeros_run[i] = 0; hold_t[i] = -1;
        end
    endtask

    // Press accepted after DEB+1 consecutive high samples, release after
    // DEB+1 consecutive lows; repeats at DLY then every PER while held.
    task automatic model_step();
        exp_t e;
        int   seen;
        int   prio[4];
        prio = '{3, 2, 0, 1};
        e = '0;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < 4; i++) begin
                seen     = hist2[i];
                hist2[i] = hist1[i];
                hist1[i] = btn_raw[i] ? 1 : 0;
                if (lvl[i] == 0) begin
                    if (seen != 0) begin
                        ones_run[i]++;
                        if (ones_run[i] == DEB + 1) begin
                            lvl[i] = 1; e.pulse[i] = 1'b1; hold_t[i] = 0; ones_run[i] = 0;
                        end
                    end else begin
                        ones_run[i] = 0;
                    end
                end else if (seen != 0) begin
                    zeros_run[i] = 0;
                    if (hold_t[i] < 0) hold_t[i] = 0;
                    else hold_t[i]++;
                    if (REN != 0 && (hold_t[i] == DLY ||
                        (hold_t[i] > DLY && (hold_t[i] - DLY) % PER == 0)))
                        e.pulse[i] = 1'b1;
                end else begin
                    hold_t[i] = -1;
                    zeros_run[i]++;
                    if (zeros_run[i] == DEB + 1) begin
                        lvl[i] = 0; zeros_run[i] = 0;
                    end
                end
                e.level[i] = (lvl[i] != 0);
            end
            for (int k = 0; k < 4; k++) begin
                if (e.pulse[prio[k]]) begin
                    e.move[prio[k]] = 1'b1;
                    break;
                end
            end
        end
        sb_q.push_back(e);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk);
            cyc++;
            model_step();
        end
    end

    // Monitor: asynchronous reset overrides whatever was predicted.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_underflow edge=%0d got=empty want=entry", cyc);
            end else begin
                e = sb_q.pop_front();
                if (rst) e = '0;
                check("level", btn_level, e.level);
                check("pulse", btn_pulse, e.pulse);
                check("move", {move_right, move_left, move_down, move_up}, e.move);
                if (rec_on && move_right) rec_log.push_back(cyc - rec_base);
            end
        end
    end

    task automatic step(input logic [3:0] v, input int n);
        btn_raw = v;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        logic [3:0] v;
        int         dur[4];
        int         exp3[6];
        exp3 = '{6, 16, 19, 22, 25, 28};

        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        step(4'b0000, 5);

        // Single press of up
        step(4'b0001, 8);
        step(4'b0000, 20);

        // Bouncing left never accepted
        repeat (5) begin
            step(4'b0100, 2);
            step(4'b0000, 2);
        end
        step(4'b0000, 20);

        // Right held: press pulse then repeats
        rec_base = cyc + 1;
        rec_on   = 1'b1;
        step(4'b1000, 29);
        step(4'b0000, 20);
        rec_on   = 1'b0;
        check_int("right_count", rec_log.size(), 6);
        for (int k = 0; k < 6 && k < rec_log.size(); k++)
            check_int("right_edge", rec_log[k], exp3[k]);

        // All four simultaneously
        step(4'b1111, 14);
        step(4'b0000, 20);

        // Up with a short glitch after acceptance
        step(4'b0001, 10);
        step(4'b0000, 2);
        step(4'b0001, 20);
        step(4'b0000, 20);

        // Reset in the middle of down repeating
        step(4'b0010, 22);
        rst = 1'b1;
        #1;
        check("rst_level", btn_level, 4'b0000);
        check("rst_pulse", btn_pulse, 4'b0000);
        check("rst_move", {move_right, move_left, move_down, move_up}, 4'b0000);
        repeat (2) begin
            @(posedge clk);
            #2;
        end
        rst = 1'b0;
        step(4'b0010, 12);
        step(4'b0000, 20);

        // Randomized independent run lengths per button
        v = 4'b0000;
        for (int i = 0; i < 4; i++) dur[i] = $urandom_range(1, 30);
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 4; i++) begin
                if (dur[i] == 0) begin
                    v[i]   = ~v[i];
                    dur[i] = $urandom_range(1, 30);
                end
                dur[i]--;
            end
            step(v, 1);
        end
        step(4'b0000, 20);

        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
Conditions the four raw board push-buttons (up, down, left, right) before the block-movement stage consumes them. Each channel has:
- a 2-flop synchronizer;
- a debounce FSM;
- auto-repeat, so a held button produces periodic move strobes.

Output arbitration limits the move strobes to one per cycle, with priority right > left > up > down, matching the priority of the movement stage.

Parameters:
DEB_CYCLES, 1000000, cycles the synchronized input must be stable to accept a press or release (10 ms at 100 MHz); must be >= 2.
REP_DELAY, 25000000, cycles from the accepted press to the first repeat pulse (250 ms); must be >= 2.
REP_PERIOD, 2000000, cycles between subsequent repeat pulses (20 ms); must be >= 2.
REP_EN, 1, 1 enables auto-repeat; 0 gives a single pulse per press.

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
btn_raw  in  4  raw buttons, index 0=up 1=down 2=left 3=right; asynchronous to clk
btn_level  out  4  debounced level per button
btn_pulse  out  4  1-cycle strobe per button on accepted press and on each repeat
move_up  out  1  arbitrated strobe
move_down  out  1  arbitrated strobe
move_left  out  1  arbitrated strobe
move_right  out  1  arbitrated strobe

Behaviour:
- Reset (async): synchronizers cleared to 0, all channels to IDLE, all counters 0. btn_level, btn_pulse and move_* are 0 immediately. Reset mid-operation discards any press in progress.
- Synchronizer: s1 <= raw, s2 <= s1; the FSM sees s2, which adds 2 cycles of latency.
- Counter width: clog2 of max(DEB_CYCLES, REP_DELAY, REP_PERIOD). The counter never wraps; it is cleared on every state transition.
- Channel FSM transitions:
  - IDLE: s2=1 -> ARM, cnt=0.
  - ARM: s2=0 -> IDLE. cnt==DEB_CYCLES-1 -> HELD_DELAY, cnt=0, level=1, pulse=1. Otherwise cnt++.
  - HELD_DELAY: s2=0 -> RELEASE, cnt=0. REP_EN=1 and cnt==REP_DELAY-1 -> HELD_REPEAT, cnt=0, pulse=1. Otherwise cnt++; with REP_EN=0 the counter saturates.
  - HELD_REPEAT: s2=0 -> RELEASE, cnt=0. cnt==REP_PERIOD-1 -> pulse=1, cnt=0. Otherwise cnt++.
  - RELEASE: s2=1 -> HELD_DELAY, cnt=0, no pulse (the repeat timer restarts). cnt==DEB_CYCLES-1 -> IDLE, level=0. Otherwise cnt++. btn_level stays 1 throughout RELEASE.
- Pulses: btn_pulse is registered and high for exactly 1 cycle. Two pulses on one channel are separated by at least min(REP_DELAY, REP_PERIOD) cycles.
- Press latency: number clk edges from the first edge sampling raw=1 as edge 0. With raw held high, btn_pulse and btn_level rise after edge DEB_CYCLES+2.
- Release latency: btn_level falls after edge DEB_CYCLES+2, counted from the first edge sampling raw=0.
- Arbitration: move_* is combinational from the registered btn_pulse, adding no latency.
  - move_right = pulse[3]
  - move_left = pulse[2] & ~pulse[3]
  - move_up = pulse[0] & ~pulse[3:2]
  - move_down = pulse[1] & ~pulse[3:2] & ~pulse[0]
  - At most one move_* is high per cycle. Losing strobes are dropped, not queued; btn_pulse still shows all of them.
- Opposite buttons held together: both channels run independently; only arbitration filters them.

Decomposition:
- Shared package btn_pkg:
  - state enum {IDLE, ARM, HELD_DELAY, HELD_REPEAT, RELEASE};
  - index constants BTN_UP=0, BTN_DOWN=1, BTN_LEFT=2, BTN_RIGHT=3;
  - 100 MHz default timing constants.
- Sub-module debounce_channel: synchronizer, FSM and counter, with outputs level and pulse. It is instantiated 4 times.
- Arbitration stays in the top level.

Test Plan:
All scenarios use DEB_CYCLES=4, REP_DELAY=10, REP_PERIOD=3, REP_EN=1.
1. Raw up high from edge 0 for 8 edges, then low -> btn_pulse[0] and move_up high for the cycle after edge 6 only. btn_level[0] rises after edge 6 and falls after edge 14.
2. Raw left toggling every 2 cycles for 20 cycles, then low -> btn_pulse[2], btn_level[2] and move_left never assert.
3. Raw right held 30 edges -> move_right pulses after edges 6, 16, 19, 22, 25 and 28. btn_level[3] stays 1 from edge 6 until 6 edges after release.
4. All four raw inputs rise on the same edge, held -> btn_pulse=4'b1111 after edge 6; only move_right=1 that cycle; btn_level=4'b1111.
5. Up held past edge 6, then a 2-cycle low glitch at edge 10 -> btn_level[0] stays 1. No press pulse at glitch recovery; next repeat at 10 cycles after re-entry to HELD_DELAY.
6. rst asserted mid-HELD_REPEAT with raw down still high -> all outputs 0 immediately. After rst deasserts, btn_pulse[1] occurs after edge 6 relative to the first post-reset sampling edge.
